// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_CNT_W  = 32;

  typedef struct packed {
    logic [DEF_RD_W-1:0] rd;
    logic                reg_write;
  } wb_sideband_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with valid/ready handshake and 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t state_q, state_d;

  // p0 = main register (drives out_*), p1 = skid register
  logic              vld_p0, vld_p1;
  logic [DATA_W-1:0] data_p0, data_p1;
  logic [RD_W-1:0]   rd_p0, rd_p1;
  logic              we_p0, we_p1;

  logic accept, pop;
  logic load_main, load_skid, move_skid;

  // in_ready is the inverted skid valid flop: no path from out_ready
  assign in_ready = ~vld_p1;
  assign accept   = in_valid & in_ready;
  assign pop      = vld_p0 & out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end
        end
        TWO: begin
          if (pop) begin
            state_d   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p0  <= (state_d != EMPTY);
      vld_p1  <= (state_d == TWO);
    end
  end

  // Main register: loads from input or from skid; fields survive flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_p0 <= '0;
      rd_p0   <= '0;
      we_p0   <= 1'b0;
    end else if (load_main) begin
      data_p0 <= in_data;
      rd_p0   <= in_rd;
      we_p0   <= in_reg_write;
    end else if (move_skid) begin
      data_p0 <= data_p1;
      rd_p0   <= rd_p1;
      we_p0   <= we_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      data_p1 <= in_data;
      rd_p1   <= in_rd;
      we_p1   <= in_reg_write;
    end
  end

  assign out_valid     = vld_p0;
  assign out_data      = data_p0;
  assign out_rd        = rd_p0;
  assign out_reg_write = we_p0 & vld_p0;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (vld_p0 & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~vld_p0),
    .cnt (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table plus hand-written corner sequences.
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_reg_write, out_ready;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_ready, out_valid, out_reg_write;
  logic [31:0] out_data, stall_cnt, bubble_cnt;
  logic [4:0]  out_rd;

  logic        in_ready3, out_valid3, out_reg_write3;
  logic [31:0] out_data3;
  logic [4:0]  out_rd3;
  logic [2:0]  stall3, bubble3;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_rd(out_rd3), .out_reg_write(out_reg_write3),
    .stall_cnt(stall3), .bubble_cnt(bubble3)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        rdy;
    logic        vld;
    logic [31:0] data;
    logic        we;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic rdy, input logic vld, input logic [31:0] data,
                              input logic we);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.rdy = rdy; v.vld = vld; v.data = data; v.we = we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic w,
                     input logic r, input logic f);
    in_valid     = v;
    in_data      = d;
    in_rd        = d[4:0];
    in_reg_write = w;
    out_ready    = r;
    flush        = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_rd = '0; in_reg_write = 1'b0; out_ready = 1'b0;

    // reset state
    cyc(1, 32'hEE, 1, 1, 0);
    cyc(1, 32'hEE, 1, 1, 0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst out_reg_write", {31'b0, out_reg_write}, 32'd0);
    chk("rst stall_cnt", stall_cnt, 32'd0);
    chk("rst bubble_cnt", bubble_cnt, 32'd0);
    rst = 1'b1;

    // streaming 1..8, then backpressure from the third entry
    for (int i = 0; i < 8; i++) vecs[i] = mk(1, i + 1, 1, 1, 1, i + 1, 1);
    vecs[8]  = mk(0, 32'h00, 1, 1, 0, 32'h00, 0);
    vecs[9]  = mk(1, 32'h11, 1, 1, 1, 32'h11, 1);
    vecs[10] = mk(1, 32'h12, 1, 1, 1, 32'h12, 1);
    vecs[11] = mk(1, 32'h13, 0, 0, 1, 32'h12, 1);
    vecs[12] = mk(1, 32'h14, 0, 0, 1, 32'h12, 1);
    vecs[13] = mk(1, 32'h14, 0, 0, 1, 32'h12, 1);
    vecs[14] = mk(1, 32'h14, 1, 1, 1, 32'h13, 1);
    vecs[15] = mk(1, 32'h14, 1, 1, 1, 32'h14, 1);
    vecs[16] = mk(0, 32'h00, 1, 1, 0, 32'h00, 0);

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].iv, vecs[i].d, vecs[i].iv, vecs[i].ordy, 0);
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].rdy});
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].vld});
      chk($sformatf("vec%0d out_reg_write", i), {31'b0, out_reg_write}, {31'b0, vecs[i].we});
      if (vecs[i].vld) begin
        chk($sformatf("vec%0d out_data", i), out_data, vecs[i].data);
        chk($sformatf("vec%0d out_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].data[4:0]});
      end
    end
    chk("backpressure stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
    chk("backpressure stall_cnt w3", {29'b0, stall3}, PERF ? 32'd3 : 32'd0);

    // flush in TWO with in_valid high
    cyc(1, 32'h21, 1, 0, 0);
    cyc(1, 32'h22, 1, 0, 0);
    chk("two in_ready", {31'b0, in_ready}, 32'd0);
    chk("two out_data", out_data, 32'h21);
    cyc(1, 32'hAA, 1, 0, 1);
    chk("flush2 out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush2 in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h0, 0, 1, 0);
      chk($sformatf("post flush2 out_valid %0d", i), {31'b0, out_valid}, 32'd0);
    end

    // flush in ONE with an acceptable input: the accept is dropped
    cyc(1, 32'h31, 1, 1, 0);
    chk("one out_data", out_data, 32'h31);
    cyc(1, 32'hAB, 1, 1, 1);
    chk("flush1 out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush1 in_ready", {31'b0, in_ready}, 32'd1);
    cyc(0, 32'h0, 0, 1, 0);
    chk("post flush1 out_valid", {31'b0, out_valid}, 32'd0);

    // write-enable gating and bubble counting
    rst = 1'b0;
    cyc(0, 32'h0, 0, 1, 0);
    rst = 1'b1;
    cyc(1, 32'h41, 1, 1, 0);
    chk("gate accept we", {31'b0, out_reg_write}, 32'd1);
    cyc(0, 32'h0, 1, 1, 0);
    chk("gate pop valid", {31'b0, out_valid}, 32'd0);
    chk("gate pop we", {31'b0, out_reg_write}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h0, 1, 1, 0);
      chk($sformatf("idle%0d we", i), {31'b0, out_reg_write}, 32'd0);
      chk($sformatf("idle%0d bubble_cnt", i), bubble_cnt, PERF ? 32'd2 + i : 32'd0);
    end

    // reset while in TWO
    cyc(1, 32'h51, 1, 0, 0);
    cyc(1, 32'h52, 1, 0, 0);
    chk("pre-reset in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    cyc(1, 32'h99, 1, 0, 0);
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst out_data", out_data, 32'd0);
    chk("midrst out_rd", {27'b0, out_rd}, 32'd0);
    chk("midrst out_reg_write", {31'b0, out_reg_write}, 32'd0);
    chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst stall_cnt", stall_cnt, 32'd0);
    rst = 1'b1;
    cyc(1, 32'h55, 1, 1, 0);
    chk("post-reset valid", {31'b0, out_valid}, 32'd1);
    chk("post-reset data", out_data, 32'h55);
    cyc(0, 32'h0, 0, 1, 0);
    chk("post-reset drained", {31'b0, out_valid}, 32'd0);

    // long stall: saturation on the 3-bit counter
    rst = 1'b0;
    cyc(0, 32'h0, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 32'h61, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 32'h0, 0, 0, 0);
    chk("sat stall_cnt w3", {29'b0, stall3}, PERF ? 32'd7 : 32'd0);
    chk("sat stall_cnt w32", stall_cnt, PERF ? 32'd10 : 32'd0);
    chk("sat held data", out_data3, 32'h61);
    chk("sat held valid", {31'b0, out_valid3}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, flush and an optional per-stage performance counter. It generalises the fixed MEM/WB latch into one reusable stage. The stage carries a configurable payload width plus the register-write sideband (destination register and write enable). It is instantiated between any two core stages (EX/MEM, MEM/WB) and lets downstream backpressure stall upstream without a combinational ready path.

## Interface
- DATA_W, 32: payload width in bits (ALU result, load data, immediate, and so on, packed by the instantiator)
- RD_W, 5: destination-register index width
- CNT_W, 32: width of the performance counters (used only with PIPE_STAGE_PERF_EN)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-low
- flush  in  1  discards both held entries this cycle
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept; a registered signal
- in_data  in  DATA_W  payload
- in_rd  in  RD_W  destination register
- in_reg_write  in  1  register-write enable
- out_valid  out  1  stage holds an entry for downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload
- out_rd  out  RD_W  destination register
- out_reg_write  out  1  write enable; forced 0 whenever out_valid is 0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_STAGE_PERF_EN only)
- bubble_cnt  out  CNT_W  cycles with out_valid=0 (PIPE_STAGE_PERF_EN only)

## Operation
- Storage: a main register (drives the out_* ports) and a skid register, each with its own valid bit.
- State machine:
  - EMPTY: no entry held.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept with pop: main register loads the input.
  - ONE → EMPTY on pop without accept.
  - ONE → TWO on accept without pop: the input goes to the skid register.
  - TWO → ONE on pop: the skid register moves to main.
  - TWO holds without pop; accept cannot happen in TWO.
- in_ready = (state != TWO), registered.
- Flush has priority over every other event. Next state is EMPTY, both valid bits clear, and any accept in the same cycle is dropped. in_ready is 1 on the next cycle.
- Data fields are not cleared on flush. Consumers must qualify every field with out_valid.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush.
- Reset values (rst=0 at a rising edge):
  - state EMPTY
  - out_valid 0, out_data 0, out_rd 0, out_reg_write 0
  - in_ready 1
  - counters 0
- Reset wins over flush.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- Throughput: 1 entry per cycle while out_ready=1.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Stall behaviour: if out_ready drops, at most one further entry is absorbed (into the skid register). in_ready goes low on the following cycle.
- Reset mid-operation: any held entries are lost. The first cycle after reset behaves as EMPTY.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - stall_cnt and bubble_cnt are present.
  - Each increments by 1 per qualifying cycle, saturating at all-ones.
  - Counters are cleared by reset only; flush does not clear them.
- PIPE_STAGE_PERF_EN undefined:
  - Both counter ports are tied to 0.
  - No counter flops are synthesised.
  - Datapath behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - typedef pipe_state_t, an enum {EMPTY, ONE, TWO}
  - localparams for the default DATA_W, RD_W and CNT_W
  - typedef wb_sideband_t, a packed struct of rd and reg_write
- One natural sub-module, pipe_sat_counter: a CNT_W saturating counter with an increment enable. It is instantiated twice under PIPE_STAGE_PERF_EN.

## Test plan
- Streaming: out_ready=1, send data 1..8 back-to-back → out_data shows 1..8 on consecutive cycles, each one cycle after acceptance; in_ready stays 1.
- Backpressure: stream with out_ready=0 from cycle 3 → exactly one extra entry is absorbed and in_ready falls. On release, order is preserved with no loss or duplication; stall_cnt equals the number of held cycles.
- Flush in TWO with in_valid=1 (data 0xAA) → next cycle out_valid=0, 0xAA is never emitted, in_ready=1.
- Invalid gating: in_reg_write=1 accepted, then popped, then idle → out_reg_write=0 while out_valid=0; bubble_cnt increments each idle cycle.
- Reset mid-stream in TWO with rst=0 → next cycle all outputs at their reset values and in_ready=1; the first post-reset input (0x55) appears after 1 cycle.
- Saturation with CNT_W=3 and PIPE_STAGE_PERF_EN defined: hold the stall for 10 cycles → stall_cnt=7.
